// File: rtl/pdp8_disk_dma_if.sv
// Memory-side and IDE-side signal bundle of the PDP-8 disk DMA front end.
// master = DMA front end, slave = memory / IDE single-sector engine.
interface pdp8_disk_dma_if;
  logic        mem_req;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;
  logic        mem_ack;

  logic [23:0] ide_lba;
  logic        ide_read_req;
  logic        ide_write_req;
  logic        ide_done;
  logic        ide_error;
  logic [7:0]  ide_buf_addr;
  logic        ide_buf_rd;
  logic        ide_buf_wr;
  logic [11:0] ide_buf_wdata;
  logic [11:0] ide_buf_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack,
    output ide_lba, ide_read_req, ide_write_req,
    input  ide_done, ide_error,
    input  ide_buf_addr, ide_buf_rd, ide_buf_wr, ide_buf_wdata,
    output ide_buf_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack,
    input  ide_lba, ide_read_req, ide_write_req,
    output ide_done, ide_error,
    output ide_buf_addr, ide_buf_rd, ide_buf_wr, ide_buf_wdata,
    input  ide_buf_rdata
  );
endinterface

// File: rtl/pdp8_disk_dma.sv
// Block-transfer DMA between PDP-8 memory and a 256x12 sector buffer shared with the IDE engine.
// Optional: define DISK_DMA_ZEROFILL_EN to zero the unused tail of a short write sector.
module pdp8_disk_dma #(
  parameter logic [23:0] BLOCK_BASE = 24'h000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_go,
  input  logic        cmd_write,
  input  logic [15:0] cmd_block,
  input  logic [14:0] cmd_ma,
  input  logic [7:0]  cmd_wc,
  output logic        busy,
  output logic        done,
  output logic        error,
  pdp8_disk_dma_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
`ifdef DISK_DMA_ZEROFILL_EN
    ZERO,
`endif
    IDE,
    DRAIN,
    FIN
  } state_t;

  state_t      state_q, state_d;
  logic [14:0] ma_q;
  logic [8:0]  count_q;
  logic [8:0]  wc_q;
  logic [7:0]  ptr_q;
  logic        write_q;
  logic        error_q;
  logic [23:0] lba_q;
  logic        drain_wr_q;
  logic [11:0] dma_rdata_q;
  logic [11:0] ide_rdata_q;

  logic        mem_req, mem_we;
  logic        ide_rd_req, ide_wr_req;
  logic        dma_buf_we, dma_buf_rd;
  logic [11:0] dma_buf_wdata;

  logic [8:0]  wc_in;
  logic [14:0] ma_next;

  assign wc_in   = (cmd_wc == 8'd0) ? 9'd256 : {1'b0, cmd_wc};
  // Only the 12-bit address wraps; the field bits select the memory bank and stay put.
  assign ma_next = {ma_q[14:12], ma_q[11:0] + 12'd1};

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d       = state_q;
    busy          = (state_q != IDLE);
    done          = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    ide_rd_req    = 1'b0;
    ide_wr_req    = 1'b0;
    dma_buf_we    = 1'b0;
    dma_buf_rd    = 1'b0;
    dma_buf_wdata = '0;
    case (state_q)
      IDLE: begin
        if (cmd_go) state_d = cmd_write ? FILL : IDE;
      end
      FILL: begin
        mem_req = 1'b1;
        if (bus.mem_ack) begin
          dma_buf_we    = 1'b1;
          dma_buf_wdata = bus.mem_rdata;
          if (count_q == 9'd1) begin
`ifdef DISK_DMA_ZEROFILL_EN
            state_d = (ptr_q != 8'hFF) ? ZERO : IDE;
`else
            state_d = IDE;
`endif
          end
        end
      end
`ifdef DISK_DMA_ZEROFILL_EN
      ZERO: begin
        dma_buf_we = 1'b1;
        if (ptr_q == 8'hFF) state_d = IDE;
      end
`endif
      IDE: begin
        ide_wr_req = write_q;
        ide_rd_req = !write_q;
        if (bus.ide_done) state_d = write_q ? FIN : DRAIN;
      end
      DRAIN: begin
        if (!drain_wr_q) begin
          dma_buf_rd = 1'b1;
        end else begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          if (bus.mem_ack && count_q == 9'd1) state_d = FIN;
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      ma_q       <= '0;
      count_q    <= '0;
      wc_q       <= '0;
      ptr_q      <= '0;
      write_q    <= 1'b0;
      error_q    <= 1'b0;
      lba_q      <= '0;
      drain_wr_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_go) begin
            ma_q       <= cmd_ma;
            wc_q       <= wc_in;
            count_q    <= wc_in;
            ptr_q      <= '0;
            write_q    <= cmd_write;
            error_q    <= 1'b0;
            lba_q      <= BLOCK_BASE + {8'b0, cmd_block};
            drain_wr_q <= 1'b0;
          end
        end
        FILL: begin
          if (bus.mem_ack) begin
            ptr_q   <= ptr_q + 8'd1;
            ma_q    <= ma_next;
            count_q <= count_q - 9'd1;
          end
        end
`ifdef DISK_DMA_ZEROFILL_EN
        ZERO: ptr_q <= ptr_q + 8'd1;
`endif
        IDE: begin
          if (bus.ide_done) begin
            error_q <= bus.ide_error;
            ptr_q   <= '0;
            count_q <= wc_q;
          end
        end
        DRAIN: begin
          if (!drain_wr_q) begin
            drain_wr_q <= 1'b1;
          end else if (bus.mem_ack) begin
            drain_wr_q <= 1'b0;
            ptr_q      <= ptr_q + 8'd1;
            ma_q       <= ma_next;
            count_q    <= count_q - 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Sector buffer: the IDE engine owns the single port while the request is up, the DMA otherwise.
  logic [11:0] sector_mem [256];
  logic        ide_own;
  logic [7:0]  buf_addr;
  logic        buf_we;
  logic [11:0] buf_wdata;

  assign ide_own   = (state_q == IDE);
  assign buf_addr  = ide_own ? bus.ide_buf_addr  : ptr_q;
  assign buf_we    = ide_own ? bus.ide_buf_wr    : dma_buf_we;
  assign buf_wdata = ide_own ? bus.ide_buf_wdata : dma_buf_wdata;

  // NOTE: the RAM array itself is never reset; only its output registers are.
  always_ff @(posedge clk) begin
    if (buf_we) sector_mem[buf_addr] <= buf_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ide_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      if (ide_own && bus.ide_buf_rd) ide_rdata_q <= sector_mem[buf_addr];
      if (dma_buf_rd)                dma_rdata_q <= sector_mem[buf_addr];
    end
  end

  assign error             = error_q;
  assign bus.mem_req       = mem_req;
  assign bus.mem_we        = mem_we;
  assign bus.mem_addr      = ma_q;
  assign bus.mem_wdata     = dma_rdata_q;
  assign bus.ide_lba       = lba_q;
  assign bus.ide_read_req  = ide_rd_req;
  assign bus.ide_write_req = ide_wr_req;
  assign bus.ide_buf_rdata = ide_rdata_q;

endmodule

// File: tb/tb_pdp8_disk_dma.sv
// Directed bench for pdp8_disk_dma: memory responder, IDE engine emulation, offset-LBA instance.
module tb_pdp8_disk_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_go, cmd_go2, cmd_write;
  logic [15:0] cmd_block;
  logic [14:0] cmd_ma;
  logic [7:0]  cmd_wc;
  logic        busy, done, error;
  logic        busy2, done2, error2;

  int n_vec = 0;
  int n_bad = 0;

  pdp8_disk_dma_if bus_if ();
  pdp8_disk_dma_if bus2_if ();

  pdp8_disk_dma dut (
    .clk(clk), .reset(reset),
    .cmd_go(cmd_go), .cmd_write(cmd_write), .cmd_block(cmd_block),
    .cmd_ma(cmd_ma), .cmd_wc(cmd_wc),
    .busy(busy), .done(done), .error(error),
    .bus(bus_if)
  );

  pdp8_disk_dma #(.BLOCK_BASE(24'hFFFFFF)) dut2 (
    .clk(clk), .reset(reset),
    .cmd_go(cmd_go2), .cmd_write(cmd_write), .cmd_block(cmd_block),
    .cmd_ma(cmd_ma), .cmd_wc(cmd_wc),
    .busy(busy2), .done(done2), .error(error2),
    .bus(bus2_if)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] pat(input logic [14:0] a);
    return a[11:0] ^ 12'o5252;
  endfunction

  // Memory responder: acks every requested cycle, logs reads and writes.
  logic [14:0] rd_log [1024];
  logic [14:0] wr_addr [1024];
  logic [11:0] wr_data [1024];
  int rd_n = 0, wr_n = 0, done_cnt = 0;

  always @(negedge clk) begin
    if (bus_if.mem_req === 1'b1) begin
      bus_if.mem_ack = 1'b1;
      if (bus_if.mem_we) begin
        if (wr_n < 1024) begin
          wr_addr[wr_n] = bus_if.mem_addr;
          wr_data[wr_n] = bus_if.mem_wdata;
        end
        wr_n++;
      end else begin
        bus_if.mem_rdata = pat(bus_if.mem_addr);
        if (rd_n < 1024) rd_log[rd_n] = bus_if.mem_addr;
        rd_n++;
      end
    end else begin
      bus_if.mem_ack = 1'b0;
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [15:0] blk, input logic [14:0] ma,
                       input logic [7:0] wc);
    cmd_write = wr; cmd_block = blk; cmd_ma = ma; cmd_wc = wc; cmd_go = 1'b1;
    step();
    cmd_go = 1'b0;
  endtask

  task automatic ide_read_buf(input logic [7:0] a, output logic [11:0] d);
    bus_if.ide_buf_addr = a; bus_if.ide_buf_rd = 1'b1;
    step();
    bus_if.ide_buf_rd = 1'b0;
    d = bus_if.ide_buf_rdata;
  endtask

  task automatic ide_write_buf(input logic [7:0] a, input logic [11:0] d);
    bus_if.ide_buf_addr = a; bus_if.ide_buf_wdata = d; bus_if.ide_buf_wr = 1'b1;
    step();
    bus_if.ide_buf_wr = 1'b0;
  endtask

  task automatic ide_complete(input logic err);
    bus_if.ide_done = 1'b1; bus_if.ide_error = err;
    step();
    bus_if.ide_done = 1'b0; bus_if.ide_error = 1'b0;
  endtask

  function automatic bit cond(input int which);
    case (which)
      0:       return bus_if.ide_write_req === 1'b1;
      1:       return bus_if.ide_read_req === 1'b1;
      default: return busy === 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int which, input int budget, input string tag);
    int n = 0;
    bit hit = cond(which);
    while (!hit && n < budget) begin
      step();
      n++;
      hit = cond(which);
    end
    check(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    logic [11:0] d;
    int base_r, base_w, base_d, seq_bad;
    logic [14:0] exp_a [4];

    reset = 1'b1; cmd_go = 1'b0; cmd_go2 = 1'b0; cmd_write = 1'b0;
    cmd_block = '0; cmd_ma = '0; cmd_wc = '0;
    bus_if.mem_ack = 1'b0; bus_if.mem_rdata = '0;
    bus_if.ide_done = 1'b0; bus_if.ide_error = 1'b0; bus_if.ide_buf_addr = '0;
    bus_if.ide_buf_rd = 1'b0; bus_if.ide_buf_wr = 1'b0; bus_if.ide_buf_wdata = '0;
    bus2_if.mem_ack = 1'b0; bus2_if.mem_rdata = '0;
    bus2_if.ide_done = 1'b0; bus2_if.ide_error = 1'b0; bus2_if.ide_buf_addr = '0;
    bus2_if.ide_buf_rd = 1'b0; bus2_if.ide_buf_wr = 1'b0; bus2_if.ide_buf_wdata = '0;
    step(); step();
    reset = 1'b0;
    step();

    // Reset values
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_mem_req", 32'(bus_if.mem_req), 0);
    check("rst_mem_we", 32'(bus_if.mem_we), 0);
    check("rst_mem_addr", 32'(bus_if.mem_addr), 0);
    check("rst_mem_wdata", 32'(bus_if.mem_wdata), 0);
    check("rst_ide_lba", 32'(bus_if.ide_lba), 0);
    check("rst_ide_rd_req", 32'(bus_if.ide_read_req), 0);
    check("rst_ide_wr_req", 32'(bus_if.ide_write_req), 0);
    check("rst_ide_rdata", 32'(bus_if.ide_buf_rdata), 0);

    // Offset LBA wraps modulo 2^24: FFFFFF + 2 = 000001
    cmd_write = 1'b0; cmd_block = 16'd2; cmd_ma = '0; cmd_wc = 8'd1; cmd_go2 = 1'b1;
    step();
    cmd_go2 = 1'b0;
    check("lba_wrap", 32'(bus2_if.ide_lba), 32'h000001);
    check("lba_wrap_busy", 32'(busy2), 1);
    check("lba_wrap_rd_req", 32'(bus2_if.ide_read_req), 1);

    // Write block 5, ma 0200, wc 0 (256 words)
    base_r = rd_n; base_d = done_cnt;
    issue(1'b1, 16'd5, 15'o00200, 8'd0);
    check("w256_busy", 32'(busy), 1);
    wait_for(0, 400, "w256_ide_write_req");
    check("w256_reads", 32'(rd_n - base_r), 256);
    check("w256_first_addr", 32'(rd_log[base_r]), 32'o00200);
    check("w256_last_addr", 32'(rd_log[base_r + 255]), 32'o00577);
    seq_bad = 0;
    for (int i = 0; i < 256; i++) if (rd_log[base_r + i] !== 15'(15'o00200 + i)) seq_bad++;
    check("w256_addr_seq", 32'(seq_bad), 0);
    check("w256_lba", 32'(bus_if.ide_lba), 32'h000005);
    issue(1'b0, 16'd9, 15'o01000, 8'd1);
    check("go_busy_ignored_lba", 32'(bus_if.ide_lba), 32'h000005);
    check("go_busy_wr_req_held", 32'(bus_if.ide_write_req), 1);
    check("go_busy_no_rd_req", 32'(bus_if.ide_read_req), 0);
    ide_read_buf(8'd0, d);
    check("w256_buf0", 32'(d), 32'(pat(15'o00200)));
    ide_read_buf(8'd255, d);
    check("w256_buf255", 32'(d), 32'(pat(15'o00577)));
    check("w256_req_still_held", 32'(bus_if.ide_write_req), 1);
    ide_complete(1'b0);
    check("w256_req_dropped", 32'(bus_if.ide_write_req), 0);
    check("w256_done", 32'(done), 1);
    check("w256_busy_fin", 32'(busy), 1);
    check("w256_error", 32'(error), 0);
    step();
    check("w256_done_low", 32'(done), 0);
    check("w256_busy_low", 32'(busy), 0);
    check("w256_one_done", 32'(done_cnt - base_d), 1);

    // Read wc 4 at 0o17776: field-preserving wrap of the memory address
    base_w = wr_n;
    issue(1'b0, 16'd7, 15'o17776, 8'd4);
    wait_for(1, 20, "r4_ide_read_req");
    check("r4_lba", 32'(bus_if.ide_lba), 32'h000007);
    for (int i = 0; i < 4; i++) ide_write_buf(8'(i), 12'(i + 1));
    ide_complete(1'b0);
    check("r4_req_dropped", 32'(bus_if.ide_read_req), 0);
    wait_for(2, 40, "r4_idle");
    check("r4_writes", 32'(wr_n - base_w), 4);
    exp_a[0] = 15'o17776; exp_a[1] = 15'o17777; exp_a[2] = 15'o10000; exp_a[3] = 15'o10001;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("r4_addr%0d", i), 32'(wr_addr[base_w + i]), 32'(exp_a[i]));
      check($sformatf("r4_data%0d", i), 32'(wr_data[base_w + i]), 32'(i + 1));
    end

    // IDE strobes outside the IDE state: write ignored, read data holds
    ide_write_buf(8'd3, 12'o7777);
    ide_read_buf(8'd3, d);
    check("idle_rdata_holds", 32'(d), 32'(pat(15'o00577)));

    // Short write, wc 3: tail is zero-filled only with the macro
    base_r = rd_n;
    issue(1'b1, 16'd1, 15'o00100, 8'd3);
    wait_for(0, 600, "w3_ide_write_req");
    check("w3_reads", 32'(rd_n - base_r), 3);
    for (int i = 0; i < 3; i++) begin
      ide_read_buf(8'(i), d);
      check($sformatf("w3_buf%0d", i), 32'(d), 32'(pat(15'(15'o00100 + i))));
    end
    ide_read_buf(8'd3, d);
`ifdef DISK_DMA_ZEROFILL_EN
    check("w3_buf3", 32'(d), 0);
`else
    check("w3_buf3", 32'(d), 4);
`endif
    ide_read_buf(8'd100, d);
`ifdef DISK_DMA_ZEROFILL_EN
    check("w3_buf100", 32'(d), 0);
`else
    check("w3_buf100", 32'(d), 32'(pat(15'(15'o00200 + 100))));
`endif
    ide_read_buf(8'd255, d);
`ifdef DISK_DMA_ZEROFILL_EN
    check("w3_buf255", 32'(d), 0);
`else
    check("w3_buf255", 32'(d), 32'(pat(15'o00577)));
`endif
    ide_complete(1'b0);
    wait_for(2, 10, "w3_idle");

    // Read with IDE error: drain still runs, error sticks
    base_w = wr_n; base_d = done_cnt;
    issue(1'b0, 16'd3, 15'o04000, 8'd2);
    wait_for(1, 20, "rerr_ide_read_req");
    ide_write_buf(8'd0, 12'o1111);
    ide_write_buf(8'd1, 12'o2222);
    ide_complete(1'b1);
    check("rerr_error_set", 32'(error), 1);
    check("rerr_busy", 32'(busy), 1);
    wait_for(2, 40, "rerr_idle");
    check("rerr_writes", 32'(wr_n - base_w), 2);
    check("rerr_data0", 32'(wr_data[base_w]), 32'o1111);
    check("rerr_addr1", 32'(wr_addr[base_w + 1]), 32'o04001);
    check("rerr_data1", 32'(wr_data[base_w + 1]), 32'o2222);
    check("rerr_done", 32'(done_cnt - base_d), 1);
    check("rerr_error_sticky", 32'(error), 1);

    // Next command clears error; reset mid-DRAIN aborts
    issue(1'b0, 16'd0, 15'o00300, 8'd2);
    check("next_go_clears_error", 32'(error), 0);
    wait_for(1, 20, "rst_ide_read_req");
    ide_complete(1'b0);
    step();
    check("drain_mem_req", 32'(bus_if.mem_req), 1);
    check("drain_mem_we", 32'(bus_if.mem_we), 1);
    check("drain_mem_wdata", 32'(bus_if.mem_wdata), 32'o1111);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_mem_req", 32'(bus_if.mem_req), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_lba", 32'(bus_if.ide_lba), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pdp8_disk_dma.md
# pdp8_disk_dma

Block-transfer DMA front end for the IDE single-sector engine. Accepts a disk command (block number, memory address, word count, direction) from the PDP-8 disk controller IOT logic, owns the 256 x 12 sector buffer, and moves data between PDP-8 memory and that buffer. It sequences the IDE engine's read/write request and reports completion and error to the controller.

## Interface
- BLOCK_BASE, 24'h000000: LBA offset added to every block number.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high; clock clk.
- cmd_go  in  1  start pulse; sampled only in IDLE.
- cmd_write  in  1  1 = memory to disk, 0 = disk to memory.
- cmd_block  in  16  disk block number.
- cmd_ma  in  15  start memory address (field[14:12], addr[11:0]).
- cmd_wc  in  8  word count; 0 means 256.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky error of last command.
- mem_req  out  1  memory cycle request.
- mem_we  out  1  1 = write memory.
- mem_addr  out  15  memory address.
- mem_wdata  out  12  memory write data.
- mem_rdata  in  12  memory read data, valid with mem_ack.
- mem_ack  in  1  one-cycle acknowledge.
- ide_lba  out  24  sector address to IDE engine.
- ide_read_req  out  1  level request, held until ide_done.
- ide_write_req  out  1  level request, held until ide_done.
- ide_done  in  1  one-cycle IDE completion pulse.
- ide_error  in  1  IDE error, sampled with ide_done.
- ide_buf_addr  in  8  IDE-side buffer address.
- ide_buf_rd  in  1  IDE-side buffer read strobe.
- ide_buf_wr  in  1  IDE-side buffer write strobe.
- ide_buf_wdata  in  12  IDE-side buffer write data.
- ide_buf_rdata  out  12  IDE-side buffer read data.

## Operation
- States: IDLE, FILL, ZERO, IDE, DRAIN, FIN.
- IDLE: on cmd_go latch ma, wc (0 -> 256 in 9-bit count), write flag; ide_lba <= BLOCK_BASE + {8'b0, cmd_block} mod 2^24; clear error; busy <= 1; next FILL if write else IDE.
- FILL: mem_req=1, mem_we=0, mem_addr=ma; on mem_ack write mem_rdata to buffer[ptr], ptr++, ma++, count--; count 0 -> ZERO (ptr!=0, macro on) else IDE.
- ZERO: write 0 to buffer[ptr], ptr++ each cycle until ptr wraps to 0; then IDE.
- IDE: assert ide_write_req or ide_read_req; IDE port owns buffer. On ide_done: drop request (registered, low the next cycle), error <= ide_error; write -> FIN; read -> DRAIN with ptr=0, count=wc.
- DRAIN: read buffer[ptr] (1-cycle), then mem_req=1, mem_we=1, mem_wdata=data, mem_addr=ma held until mem_ack; ptr++, ma++, count--; count 0 -> FIN.
- FIN: done=1 one cycle, busy <= 0, next IDLE.
- ma increment: addr[11:0] wraps 7777 -> 0000; field bits unchanged.
- Buffer port serialisation: DMA-side access only in FILL/ZERO/DRAIN; IDE-side strobes outside IDE state ignored (no write, rdata holds).
- Read with ide_error=1: DRAIN still performed; error stays 1 until next cmd_go.
- cmd_go while busy: ignored.

## Timing
- Reset values: busy 0, done 0, error 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, ide_lba 0, ide_read_req 0, ide_write_req 0, ide_buf_rdata 0. Reset mid-operation aborts immediately to IDLE; buffer contents undefined.
- IDE buffer read: ide_buf_rdata valid the cycle after ide_buf_rd (registered RAM).
- IDE buffer write: takes effect at the edge where ide_buf_wr=1.
- Request drop: ide_*_req low in the cycle after ide_done so the IDE engine, on returning to ready, sees no restart.
- busy high from the cycle after cmd_go through the FIN cycle; done coincides with the last busy cycle.
- FILL: 1 word per mem_ack, minimum 1 cycle/word; DRAIN: minimum 2 cycles/word (buffer read + req).

## Configuration
- DISK_DMA_ZEROFILL_EN defined: write with wc<256 zero-fills buffer[wc..255] (ZERO state) before IDE request; sector tail on disk is 0000.
- Undefined: ZERO state absent; tail of written sector carries stale buffer contents.

## Test plan
- Write, block 5, ma 0o00200, wc 0: 256 mem reads 0o00200..0o00577; ide_lba=0x000005, ide_write_req held until ide_done, dropped next cycle; done 1 cycle.
- Read, wc 4, ma 0o17776, ide fills buffer 1,2,3,4: memory writes to 0o17776, 0o17777, 0o10000, 0o10001 (field-preserving wrap).
- Write wc 3 with DISK_DMA_ZEROFILL_EN: IDE reads buffer[3..255] = 0000; without macro, same positions return prior contents.
- Read with ide_error=1 at ide_done: DRAIN completes, done pulses, error=1; next cmd_go clears error.
- BLOCK_BASE=24'hFFFFFF, cmd_block=2: ide_lba=0x000001; cmd_go during busy ignored; reset during DRAIN: mem_req, busy low next cycle.
